// File: rtl/latch_arr_pkg.sv
// Shared types and defaults for the latch-array write sequencer.
package latch_arr_pkg;

    // Sequencer phases: a gate window is always OPEN for one cycle, then CLOSE for one.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } la_state_e;

    localparam int LA_WORDS = 8;
    localparam int LA_WIDTH = 8;

endpackage

// File: rtl/latch_gate_decode.sv
// Address to active-low one-hot gate decoder with an in-range flag.
// Purely combinational; the parent registers the result so the gates stay glitch-free.
module latch_gate_decode #(
    parameter int  WORDS = 8,
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic [AW-1:0]    addr_i,
    output logic [WORDS-1:0] gate_n_o,
    output logic             in_range_o
);

    // One comparator per row; an out-of-range address matches no row, so all gates stay high.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_gate
        assign gate_n_o[gi] = (32'(addr_i) != gi);
    end

    assign in_range_o = (32'(addr_i) < $unsigned(WORDS));

endmodule

// File: rtl/latch_array_wr_seq.sv
// Write-port sequencer for a bank of negative-level latches.
// Each accepted request opens one gate (or all gates for a clear) for exactly one cycle,
// followed by one all-closed cycle during which D is held, so the latches never see D
// change on the edge where their gate closes.
module latch_array_wr_seq
    import latch_arr_pkg::*;
#(
    parameter int  WORDS = LA_WORDS,
    parameter int  WIDTH = LA_WIDTH,
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    output logic [WIDTH-1:0] D,
    output logic [WORDS-1:0] GN,
    output logic             busy,
    output logic             err
);

    la_state_e        state_q;
    logic [WIDTH-1:0] d_q;
    logic [WORDS-1:0] gn_q;
    logic             err_q;

    logic [WORDS-1:0] dec_gn_n;
    logic             dec_in_range;

    latch_gate_decode #(
        .WORDS (WORDS)
    ) u_decode (
        .addr_i     (wr_addr),
        .gate_n_o   (dec_gn_n),
        .in_range_o (dec_in_range)
    );

    // A new window may start only when no gate is open; clr blocks writes while it is asserted.
    assign wr_ready = ((state_q == IDLE) || (state_q == CLOSE)) && !clr;

    // Sequencer FSM with registered gate/data outputs; D only loads on edges where all gates are already high.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            d_q     <= '0;
            gn_q    <= '1;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, CLOSE: begin
                    if (clr) begin
                        // Level-sensitive clear: repeats every two cycles while held.
                        d_q     <= '0;
                        gn_q    <= '0;
                        state_q <= OPEN;
                    end else if (wr_valid) begin
                        d_q     <= wr_data;
                        // Out-of-range writes still run the full window but open no gate.
                        gn_q    <= dec_in_range ? dec_gn_n : '1;
                        state_q <= OPEN;
                        if (!dec_in_range) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        gn_q    <= '1;
                        state_q <= IDLE;
                    end
                end
                OPEN: begin
                    // Latches capture as gates rise here; D is deliberately left untouched.
                    gn_q    <= '1;
                    state_q <= CLOSE;
                end
                default: begin
                    gn_q    <= '1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign D    = d_q;
    assign GN   = gn_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule
